fpu_cvt_sw: RTL and testbench

- Multi-cycle integer-to-single-precision encoder implementing cvt.s.w and cvt.s.wu.
- Produces IEEE-754 binary32 operands for the combinational FPU datapath, which only consumes float-encoded values.
- Sits between the integer register-file read port and the FP register-file write port.
- Valid/ready handshake on both sides; iterative normalization shifter.

---
 rtl/fpu_cvt_sw_if.sv | 21 ++
 rtl/fpu_cvt_sw.sv | 135 +++++++++++++
 tb/tb_fpu_cvt_sw.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_cvt_sw_if.sv
// Request/result handshake bundle between integer read port, fpu_cvt_sw and FP write port.
// Valid/ready on both sides; master drives requests and consumes results.
interface fpu_cvt_sw_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fpu_cvt_sw.sv
// Iterative int32/uint32 -> binary32 encoder; 1 cycle for zero else 3 + normalization steps; result held in DONE until out_ready.
// FPU_CVT_RNE_EN selects round-to-nearest-even, otherwise truncation; accepts only in IDLE (one bubble after each result).
module fpu_cvt_sw #(
    parameter int NORM_STEP = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fpu_cvt_sw_if.slave  io,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

    localparam logic [5:0] STEP = 6'(NORM_STEP);

    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [5:0]  sc_q, sc_d;
    logic        sign_q, sign_d;
    logic [31:0] out_data_q, out_data_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;

    logic [31:0] in_mag;
    logic        in_sign;
    logic [7:0]  exp_w;
    logic [22:0] mant_w;
`ifdef FPU_CVT_RNE_EN
    logic        round_up;
    logic        mant_carry;
`endif

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        sc_d        = sc_q;
        sign_d      = sign_q;
        out_data_d  = out_data_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        in_sign = io.in_signed & io.in_data[31];
        in_mag  = in_sign ? -io.in_data : io.in_data;

        exp_w  = 8'd158 - {2'b00, sc_q};
        mant_w = mag_q[30:8];
`ifdef FPU_CVT_RNE_EN
        round_up = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
        {mant_carry, mant_w} = {1'b0, mag_q[30:8]} + {23'd0, round_up};
        // Carry out means the mantissa wrapped to zero: bump the exponent.
        if (mant_carry) begin
            exp_w = exp_w + 8'd1;
        end
`endif

        case (state_q)
            IDLE: begin
                if (io.in_valid && in_ready_q) begin
                    sign_d     = in_sign;
                    mag_d      = in_mag;
                    sc_d       = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    if (in_mag == 32'd0) begin
                        out_data_d  = 32'd0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (mag_q[31]) begin
                    state_d = PACK;
                end else if (mag_q[31 -: NORM_STEP] == '0) begin
                    mag_d = mag_q << NORM_STEP;
                    sc_d  = sc_q + STEP;
                end else begin
                    mag_d = mag_q << 1;
                    sc_d  = sc_q + 6'd1;
                end
            end
            PACK: begin
                out_data_d  = {sign_q, exp_w, mant_w};
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            sc_q        <= '0;
            sign_q      <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            sc_q        <= sc_d;
            sign_q      <= sign_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fpu_cvt_sw.sv
// Drives four converters (NORM_STEP 1,2,4,8) in lockstep and checks results and latency against an arithmetic reference.
module tb_fpu_cvt_sw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_signed = 1'b0;
    logic        out_ready = 1'b0;

    logic [3:0]  ov, ir, bz;
    logic [31:0] od [4];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_sw
        fpu_cvt_sw_if u_if ();
        assign u_if.in_valid  = in_valid;
        assign u_if.in_data   = in_data;
        assign u_if.in_signed = in_signed;
        assign u_if.out_ready = out_ready;
        assign ov[g] = u_if.out_valid;
        assign ir[g] = u_if.in_ready;
        assign od[g] = u_if.out_data;
        fpu_cvt_sw #(.NORM_STEP(1 << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .io    (u_if.slave),
            .busy  (bz[g])
        );
    end

    typedef struct {
        logic [31:0] data;
        logic        sgn;
        logic [31:0] exp_trunc;
        logic [31:0] exp_rne;
        int          lat_s4;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] magnitude(input logic [31:0] d, input logic s);
        return (s && d[31]) ? 32'(0 - d) : d;
    endfunction

    // Reference value from plain arithmetic on the integer magnitude.
    function automatic logic [31:0] model_val(input logic [31:0] d, input logic s);
        longint unsigned m, mant, rem, half;
        int p, drop, e;
        logic sign;
        sign = s && d[31];
        m = longint'(magnitude(d, s));
        if (m == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 32; i++) if (m >= (64'd1 << i)) p = i;
        e = 127 + p;
        if (p <= 23) begin
            mant = (m - (64'd1 << p)) << (23 - p);
        end else begin
            drop = p - 23;
            mant = (m >> drop) - (64'd1 << 23);
            rem  = m % (64'd1 << drop);
            half = 64'd1 << (drop - 1);
`ifdef FPU_CVT_RNE_EN
            if (rem > half || (rem == half && mant[0])) mant = mant + 1;
            if (mant == (64'd1 << 23)) begin
                mant = 0;
                e = e + 1;
            end
`else
            if (rem > 2 * half) mant = 0;
`endif
        end
        return {sign, 8'(e), 23'(mant)};
    endfunction

    // Accept-edge-inclusive cycle count, from the leading-one position advanced per the step rule.
    function automatic int model_lat(input logic [31:0] d, input logic s, input int step);
        int pos, cnt;
        logic [31:0] m;
        m = magnitude(d, s);
        if (m == 0) return 1;
        pos = 0;
        for (int i = 0; i < 32; i++) if (m[i]) pos = i;
        cnt = 0;
        while (pos < 31) begin
            pos = (pos <= 31 - step) ? pos + step : pos + 1;
            cnt++;
        end
        return 3 + cnt;
    endfunction

    task automatic run_one(input logic [31:0] d, input logic s, input logic [31:0] expv,
                           input int lat_s4, input int hold);
        int lat [4];
        int cyc;
        logic [31:0] held;
        chk("idle_in_ready", 64'(ir), 64'hF);
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_signed = ~s;
        for (int g = 0; g < 4; g++) lat[g] = 0;
        cyc = 1;
        while (cyc <= 60) begin
            for (int g = 0; g < 4; g++) if (ov[g] && lat[g] == 0) lat[g] = cyc;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("latency_step%0d", 1 << g), 64'(lat[g]), 64'(model_lat(d, s, 1 << g)));
            chk($sformatf("out_data_step%0d", 1 << g), 64'(od[g]), 64'(expv));
        end
        if (lat_s4 > 0) chk("latency_step4_hand", 64'(lat[2]), 64'(lat_s4));
        held = od[2];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            chk("hold_data", 64'(od[2]), 64'(held));
            chk("hold_flags", {61'd0, ir[2], bz[2], ov[2]}, 64'b011);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_idle", {52'd0, ir, bz, ov}, {52'd0, 4'hF, 4'h0, 4'h0});
    endtask

    vec_t vecs [10];

    initial begin
        bit seen;
        logic [31:0] d;
        logic s;

        vecs[0] = '{32'h00000001, 1'b1, 32'h3F800000, 32'h3F800000, 13, 0};
        vecs[1] = '{32'hFFFFFFFF, 1'b1, 32'hBF800000, 32'hBF800000, 13, 0};
        vecs[2] = '{32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 1, 0};
        vecs[3] = '{32'h80000000, 1'b1, 32'hCF000000, 32'hCF000000, 3, 10};
        vecs[4] = '{32'hFFFFFFFF, 1'b0, 32'h4F7FFFFF, 32'h4F800000, 3, 0};
        vecs[5] = '{32'h80000000, 1'b0, 32'h4F000000, 32'h4F000000, 3, 0};
        vecs[6] = '{32'h01000003, 1'b0, 32'h4B800001, 32'h4B800002, 7, 0};
        vecs[7] = '{32'h01000001, 1'b0, 32'h4B800000, 32'h4B800000, 7, 0};
        vecs[8] = '{32'h00000003, 1'b1, 32'h40400000, 32'h40400000, 12, 0};
        vecs[9] = '{32'hFFFFFFFD, 1'b1, 32'hC0400000, 32'hC0400000, 12, 3};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {52'd0, ir, bz, ov}, {52'd0, 4'hF, 4'h0, 4'h0});
        chk("reset_out_data", 64'(od[2]), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while normalizing drops the request.
        in_valid  = 1'b1;
        in_data   = 32'h00000001;
        in_signed = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_flags", {52'd0, ir, bz, ov}, {52'd0, 4'hF, 4'h0, 4'h0});
        chk("midreset_out_data", 64'(od[3]), 64'd0);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ov != 4'h0) seen = 1'b1;
        end
        chk("midreset_no_result", 64'(seen), 64'd0);

        for (int i = 0; i < 10; i++) begin
`ifdef FPU_CVT_RNE_EN
            run_one(vecs[i].data, vecs[i].sgn, vecs[i].exp_rne, vecs[i].lat_s4, vecs[i].hold);
`else
            run_one(vecs[i].data, vecs[i].sgn, vecs[i].exp_trunc, vecs[i].lat_s4, vecs[i].hold);
`endif
        end

        for (int i = 0; i < 150; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) d = ~d;
            s = 1'($urandom_range(0, 1));
            run_one(d, s, model_val(d, s), 0, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
